// File: rtl/pcileech_tx_pkg.sv
// Shared constants for the PCIe-to-USB transmit path.
package pcileech_tx_pkg;

    localparam int DWORD_W = 32;
    localparam logic [31:0] MAGIC_DEFAULT = 32'h6666_5555;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcileech_fifo_fwft_32.sv
// Circular dword buffer with first-word-fall-through head and occupancy count.
module pcileech_fifo_fwft_32 #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [31:0]              wdata,
    input  logic                     pop,
    output logic [31:0]              rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full buffer refuses pushes even when a pop frees a slot this cycle.
    assign full    = (level == LW'(DEPTH));
    assign valid   = (level != '0);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pcileech_tx_downsizer.sv
// Splits wide FIFO words into dwords (MSB first) and inserts a restart marker when idle.
module pcileech_tx_downsizer
    import pcileech_tx_pkg::*;
#(
    parameter int          IN_DW    = 256,
    parameter int          DEPTH    = 64,
    parameter logic [31:0] MAGIC    = MAGIC_DEFAULT,
    parameter bit          MAGIC_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [IN_DW-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    link_idle,
    output logic [31:0]             out_data,
    output logic                    out_valid,
    output logic                    out_empty,
    input  logic                    out_rd_en,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             magic_cnt
);

    localparam int N     = IN_DW / DWORD_W;
    localparam int IDX_W = idx_width(N);

    logic [IN_DW-1:0] sh_data;
    logic             sh_valid;
    logic [IDX_W-1:0] sh_idx;
    logic             sh_last;
    logic             armed;
    logic             fifo_full;
    logic             push_data;
    logic             push_magic;
    logic             accept;
    logic             fifo_push;
    logic [31:0]      fifo_wdata;

    assign sh_last   = (sh_idx == IDX_W'(N - 1));
    assign push_data = sh_valid && !fifo_full;
    assign in_ready  = rst_n && (!sh_valid || (sh_last && push_data));
    assign accept    = in_valid && in_ready;

    // Marker only when everything upstream and downstream is quiet; data always wins.
    assign push_magic = MAGIC_EN && armed && (level == '0) && !sh_valid
                        && !in_valid && link_idle && !push_data;

    assign fifo_push  = push_data || push_magic;
    assign fifo_wdata = push_data ? sh_data[IN_DW-1 -: DWORD_W] : MAGIC;
    assign out_empty  = ~out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data  <= '0;
            sh_valid <= 1'b0;
            sh_idx   <= '0;
        end else if (accept) begin
            sh_data  <= in_data;
            sh_valid <= 1'b1;
            sh_idx   <= '0;
        end else if (push_data) begin
            sh_data  <= sh_data << DWORD_W;
            sh_idx   <= sh_idx + 1'b1;
            if (sh_last) sh_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b1;
            magic_cnt <= '0;
        end else if (push_data) begin
            armed <= 1'b1;
        end else if (push_magic) begin
            armed     <= 1'b0;
            magic_cnt <= magic_cnt + 16'd1;
        end
    end

    pcileech_fifo_fwft_32 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (out_rd_en),
        .rdata (out_data),
        .valid (out_valid),
        .full  (fifo_full),
        .level (level)
    );

endmodule

// File: tb/tb_pcileech_tx_downsizer.sv
// Directed bench for the transmit downsizer (IN_DW=256, DEPTH=8).
module tb_pcileech_tx_downsizer;

    localparam int          IN_DW = 256;
    localparam int          DEPTH = 8;
    localparam logic [31:0] MAGIC = 32'h6666_5555;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [IN_DW-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             link_idle;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_empty;
    logic             out_rd_en;
    logic [3:0]       level;
    logic [15:0]      magic_cnt;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pcileech_tx_downsizer #(
        .IN_DW    (IN_DW),
        .DEPTH    (DEPTH),
        .MAGIC    (MAGIC),
        .MAGIC_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .link_idle (link_idle),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_empty (out_empty),
        .out_rd_en (out_rd_en),
        .level     (level),
        .magic_cnt (magic_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [IN_DW-1:0] mkword(input logic [31:0] base);
        logic [IN_DW-1:0] w;
        for (int k = 0; k < IN_DW / 32; k++) w[k*32 +: 32] = base + 32'(k);
        return w;
    endfunction

    task automatic send_word(input logic [31:0] base);
        chk("send_ready", {31'b0, in_ready}, 32'd1);
        in_data  = mkword(base);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            chk(tag, out_data, base + 32'(7 - i));
            out_rd_en = 1'b1;
            @(negedge clk);
        end
        out_rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_q [15];
        int j;
        int g;

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        link_idle = 1'b0;
        out_rd_en = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_empty", {31'b0, out_empty}, 32'd1);
        chk("rst_level",     {28'b0, level},     32'd0);
        chk("rst_magic_cnt", {16'b0, magic_cnt}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd0);

        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // empty pop
        out_rd_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("epop_level", {28'b0, level},     32'd0);
        chk("epop_valid", {31'b0, out_valid}, 32'd0);
        out_rd_en = 1'b0;

        // order
        send_word(32'd0);
        chk("order_latency", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("order_first",  out_data,        32'd7);
        chk("order_level1", {28'b0, level},  32'd1);
        repeat (7) @(negedge clk);
        chk("order_peak", {28'b0, level}, 32'd8);
        pop_check("order_data", 32'd0);
        chk("order_level_end", {28'b0, level},     32'd0);
        chk("order_magic_cnt", {16'b0, magic_cnt}, 32'd0);

        // marker
        rst_n     = 1'b0;
        link_idle = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("marker_cnt",   {16'b0, magic_cnt}, 32'd1);
        chk("marker_level", {28'b0, level},     32'd1);
        chk("marker_data",  out_data,           MAGIC);
        out_rd_en = 1'b1;
        @(negedge clk);
        out_rd_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("marker_once_level", {28'b0, level},     32'd0);
        chk("marker_once_cnt",   {16'b0, magic_cnt}, 32'd1);

        // rearm
        send_word(32'h100);
        repeat (8) @(negedge clk);
        chk("rearm_level", {28'b0, level}, 32'd8);
        pop_check("rearm_data", 32'h100);
        chk("rearm_drained", {28'b0, level}, 32'd0);
        @(negedge clk);
        chk("rearm_cnt",   {16'b0, magic_cnt}, 32'd2);
        chk("rearm_magic", out_data,           MAGIC);
        out_rd_en = 1'b1;
        @(negedge clk);
        out_rd_en = 1'b0;
        link_idle = 1'b0;

        // full
        in_data  = mkword(32'h200);
        in_valid = 1'b1;
        @(negedge clk);
        in_data = mkword(32'h300);
        g = 0;
        while (!in_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("full_second_accept", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("full_level",    {28'b0, level},    32'd8);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("full_head",     out_data,          32'h207);
        out_rd_en = 1'b1;
        @(negedge clk);
        out_rd_en = 1'b0;
        chk("full_after_pop", {28'b0, level}, 32'd7);
        @(negedge clk);
        chk("full_refill",     {28'b0, level},    32'd8);
        chk("full_refill_rdy", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < 7; k++) exp_q[k] = 32'h206 - 32'(k);
        for (int k = 0; k < 8; k++) exp_q[7 + k] = 32'h307 - 32'(k);
        j = 0;
        g = 0;
        out_rd_en = 1'b1;
        while (j < 15 && g < 60) begin
            if (out_valid) begin
                chk("full_drain", out_data, exp_q[j]);
                j++;
            end
            @(negedge clk);
            g++;
        end
        out_rd_en = 1'b0;
        chk("full_drain_count", 32'(j), 32'd15);
        @(negedge clk);
        chk("full_end_level", {28'b0, level},     32'd0);
        chk("full_end_valid", {31'b0, out_valid}, 32'd0);

        // reset mid-word
        send_word(32'h400);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", {28'b0, level},     32'd0);
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_ready", {31'b0, in_ready},  32'd0);
        chk("midrst_cnt",   {16'b0, magic_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_ready", {31'b0, in_ready}, 32'd1);
        send_word(32'h500);
        repeat (8) @(negedge clk);
        chk("midrst_level8", {28'b0, level}, 32'd8);
        pop_check("midrst_data", 32'h500);
        chk("midrst_end_level", {28'b0, level}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pcileech_tx_downsizer.md
PCILEECH_TX_DOWNSIZER -- requirements
Module: pcileech_tx_downsizer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 Parameter IN_DW, default 256: input word width; a multiple of 32, range 64..1024; N = IN_DW/32.
REQ-003 Parameter DEPTH, default 64: output buffer entries; a power of 2, range 8..4096.
REQ-004 Parameter MAGIC, default 32'h66665555: stream-restart marker dword.
REQ-005 Parameter MAGIC_EN, default 1: 1 enables marker insertion.
REQ-006 Port clk  in  1  rising-edge system clock.
REQ-007 Port rst_n  in  1  asynchronous active-low reset.
REQ-008 Port in_data  in  IN_DW  wide word from the FIFO controller.
REQ-009 Port in_valid  in  1  in_data is valid.
REQ-010 Port in_ready  out  1  the block accepts in_data this cycle.
REQ-011 Port link_idle  in  1  USB side not draining (TXE_N high).
REQ-012 Port out_data  out  32  head dword, first-word-fall-through.
REQ-013 Port out_valid  out  1  out_data is valid (buffer non-empty).
REQ-014 Port out_empty  out  1  equals ~out_valid.
REQ-015 Port out_rd_en  in  1  pop head dword.
REQ-016 Port level  out  clog2(DEPTH)+1  dwords currently buffered.
REQ-017 Port magic_cnt  out  16  markers inserted since reset; wraps modulo 2^16.

Function
REQ-018 A wide word SHALL be accepted when in_valid and in_ready are both high in the same cycle; in_ready = shifter empty, or shifter on its last dword and that dword being pushed this cycle.
REQ-019 The shifter SHALL emit the dwords of each accepted word most-significant first: in_data[IN_DW-1:IN_DW-32] first, [31:0] last.
REQ-020 One shifter dword SHALL be pushed into the buffer per cycle while the shifter holds data and level < DEPTH.
REQ-021 The dword index SHALL count 0..N-1; the shifter SHALL become empty after index N-1 is pushed, unless a new word is accepted in that same cycle.
REQ-022 The first dword of an accepted word SHALL appear on out_data no earlier than 2 cycles after acceptance when the buffer was empty.
REQ-023 Pop SHALL occur when out_rd_en is high and out_valid is high; out_rd_en while empty SHALL be ignored and SHALL change no state.
REQ-024 A push SHALL be blocked when level == DEPTH, even if a pop occurs in the same cycle.
REQ-025 Simultaneous push and pop SHALL leave level unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-026 Flag armed SHALL be 1 after reset, SHALL clear on marker insertion, and SHALL set on every data-dword push.
REQ-027 Marker insertion SHALL push MAGIC when MAGIC_EN, armed, level == 0, shifter empty, in_valid low and link_idle high all hold; at most one marker SHALL be inserted per armed episode.
REQ-028 A data push SHALL always take priority over marker insertion; both SHALL never push in the same cycle.
REQ-029 magic_cnt SHALL increment by 1 on each marker insertion.

Reset
REQ-030 While rst_n is low: out_valid=0, out_empty=1, level=0, magic_cnt=0, in_ready=0, shifter empty, pointers=0, armed=1; out_data SHALL be don't-care.
REQ-031 Reset asserted mid-word SHALL discard the partial word and all buffered dwords.
REQ-032 in_ready SHALL go high in the first cycle after rst_n deasserts.

Structure
REQ-033 Package pcileech_tx_pkg SHALL hold DWORD_W=32 and MAGIC_DEFAULT=32'h66665555.
REQ-034 The circular buffer SHALL be the sub-module pcileech_fifo_fwft_32 (parameter DEPTH; push, pop, level, FWFT head); the shifter, arming logic and counter SHALL live in the top.

Verification
REQ-035 Directed scenario "order": IN_DW=256; after reset hold link_idle=0, send one word with dword k = k (k=0 is [31:0]) -> out sequence 7,6,5,4,3,2,1,0; level peaks at 8; magic_cnt=0.
REQ-036 Directed scenario "marker": after reset, link_idle=1, no input for 10 cycles -> exactly one MAGIC pushed, magic_cnt=1, level=1; pop it, wait 10 more cycles -> no second marker.
REQ-037 Directed scenario "rearm": after a marker, send one word and drain all 8 dwords with link_idle=1 -> a second MAGIC follows, magic_cnt=2.
REQ-038 Directed scenario "full": DEPTH=8, out_rd_en=0, send 2 words -> level stops at 8, in_ready low; pop 1 dword -> level 8 again after refill; no dword is lost or duplicated.
REQ-039 Directed scenario "reset": assert rst_n low at dword index 3 -> level=0 and out_valid=0 immediately; after release, a new word streams correctly.
REQ-040 Directed scenario "empty pop": out_rd_en held high while empty -> level stays 0 and pointers are unchanged.
